// File: rtl/z_delay_line_pkg.sv
// Shared equalizer datapath constants and sizing helpers for the delay line.
package z_delay_line_pkg;

  localparam int unsigned EQ_SAMPLE_W  = 16;
  localparam int unsigned EQ_MAX_DEPTH = 64;

  // tap_sel must be at least one bit wide, even for a single-stage line
  function automatic int unsigned sel_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/z_stage.sv
// Single unit-delay register with synchronous reset, flush and enable.
module z_stage #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clear_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/z_delay_line.sv
// Tapped z^-DEPTH delay line with tap select, fill tracking and output strobe.
module z_delay_line
  import z_delay_line_pkg::*;
#(
  parameter int unsigned DATA_W = EQ_SAMPLE_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned SEL_W  = sel_width(DEPTH),
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    sample_en_i,
  input  logic                    clear_i,
  input  logic [DATA_W-1:0]       data_in_i,
  input  logic [SEL_W-1:0]        tap_sel_i,
  output logic [DATA_W*DEPTH-1:0] taps_o,
  output logic [DATA_W-1:0]       tap_out_o,
  output logic [DATA_W-1:0]       data_out_o,
  output logic                    out_valid_o,
  output logic                    primed_o,
  output logic [CNT_W-1:0]        fill_count_o
);

  logic [DATA_W-1:0] tap [DEPTH];
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic              primed_q, primed_d;
  logic              valid_q, valid_d;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [DATA_W-1:0] stage_d;
    if (k == 0) begin : g_head
      assign stage_d = data_in_i;
    end else begin : g_chain
      assign stage_d = tap[k-1];
    end

    z_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .en_i    (sample_en_i),
      .d_i     (stage_d),
      .q_o     (tap[k])
    );

    assign taps_o[k*DATA_W +: DATA_W] = tap[k];
  end

  always_comb begin
    fill_d   = fill_q;
    primed_d = primed_q;
    valid_d  = 1'b0;
    if (clear_i) begin
      fill_d   = '0;
      primed_d = 1'b0;
    end else if (sample_en_i) begin
      valid_d = 1'b1;
      if (fill_q != CNT_W'(DEPTH)) begin
        fill_d = fill_q + 1'b1;
      end
      primed_d = primed_q | (fill_d == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fill_q   <= '0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      fill_q   <= fill_d;
      primed_q <= primed_d;
      valid_q  <= valid_d;
    end
  end

  // Out-of-range selects (non power-of-two DEPTH) fall through to zero
  always_comb begin
    tap_out_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (SEL_W'(k) == tap_sel_i) begin
        tap_out_o = tap[k];
      end
    end
  end

  assign data_out_o   = tap[DEPTH-1];
  assign out_valid_o  = valid_q;
  assign primed_o     = primed_q;
  assign fill_count_o = fill_q;

endmodule

// File: tb/tb_z_delay_line.sv
// Directed bench: depth-8/16-bit, depth-6 tap select, depth-3/24-bit signed pass-through.
module tb_z_delay_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // depth 8, 16-bit
  logic         a_rst = 1'b1, a_en = 1'b0, a_clr = 1'b0;
  logic [15:0]  a_din = '0;
  logic [2:0]   a_sel = '0;
  logic [127:0] a_taps;
  logic [15:0]  a_tout, a_dout;
  logic         a_vld, a_prm;
  logic [3:0]   a_fill;

  // depth 6, 16-bit
  logic         b_rst = 1'b1, b_en = 1'b0, b_clr = 1'b0;
  logic [15:0]  b_din = '0;
  logic [2:0]   b_sel = '0;
  logic [95:0]  b_taps;
  logic [15:0]  b_tout, b_dout;
  logic         b_vld, b_prm;
  logic [2:0]   b_fill;

  // depth 3, 24-bit
  logic         c_rst = 1'b1, c_en = 1'b0, c_clr = 1'b0;
  logic [23:0]  c_din = '0;
  logic [1:0]   c_sel = '0;
  logic [71:0]  c_taps;
  logic [23:0]  c_tout, c_dout;
  logic         c_vld, c_prm;
  logic [1:0]   c_fill;

  z_delay_line #(.DATA_W(16), .DEPTH(8)) u_dut_a (
    .clk_i(clk), .rst_i(a_rst), .sample_en_i(a_en), .clear_i(a_clr), .data_in_i(a_din),
    .tap_sel_i(a_sel), .taps_o(a_taps), .tap_out_o(a_tout), .data_out_o(a_dout),
    .out_valid_o(a_vld), .primed_o(a_prm), .fill_count_o(a_fill)
  );

  z_delay_line #(.DATA_W(16), .DEPTH(6)) u_dut_b (
    .clk_i(clk), .rst_i(b_rst), .sample_en_i(b_en), .clear_i(b_clr), .data_in_i(b_din),
    .tap_sel_i(b_sel), .taps_o(b_taps), .tap_out_o(b_tout), .data_out_o(b_dout),
    .out_valid_o(b_vld), .primed_o(b_prm), .fill_count_o(b_fill)
  );

  z_delay_line #(.DATA_W(24), .DEPTH(3)) u_dut_c (
    .clk_i(clk), .rst_i(c_rst), .sample_en_i(c_en), .clear_i(c_clr), .data_in_i(c_din),
    .tap_sel_i(c_sel), .taps_o(c_taps), .tap_out_o(c_tout), .data_out_o(c_dout),
    .out_valid_o(c_vld), .primed_o(c_prm), .fill_count_o(c_fill)
  );

  typedef struct {
    logic        rst;
    logic        clr;
    logic        en;
    logic [15:0] din;
    logic [15:0] tap0;
    logic [15:0] dout;
    logic [3:0]  fill;
    logic        prm;
    logic        vld;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_strobe(input logic [15:0] d);
    a_en  = 1'b1;
    a_din = d;
    tick();
    a_en  = 1'b0;
  endtask

  initial begin
    int pulses;
    logic [15:0] exp_tap0;
    logic [15:0] gap_vals [3];

    // reset with a live strobe, then fill 1..10 back to back, then one idle cycle
    for (int i = 0; i < 3; i++) vecs.push_back('{1, 0, 1, 16'd69, 0, 0, 0, 0, 0});
    for (int d = 1; d <= 10; d++) begin
      vecs.push_back('{0, 0, 1, 16'(d), 16'(d), (d >= 8) ? 16'(d - 7) : 16'd0,
                       (d >= 8) ? 4'd8 : 4'(d), (d >= 8), 1'b1});
    end
    vecs.push_back('{0, 0, 0, 16'd0, 16'd10, 16'd3, 4'd8, 1'b1, 1'b0});

    b_rst = 1'b0;
    c_rst = 1'b0;
    foreach (vecs[i]) begin
      a_rst = vecs[i].rst;
      a_clr = vecs[i].clr;
      a_en  = vecs[i].en;
      a_din = vecs[i].din;
      tick();
      chk($sformatf("v%0d tap0", i), 32'(a_taps[15:0]), 32'(vecs[i].tap0));
      chk($sformatf("v%0d data_out", i), 32'(a_dout), 32'(vecs[i].dout));
      chk($sformatf("v%0d fill", i), 32'(a_fill), 32'(vecs[i].fill));
      chk($sformatf("v%0d primed", i), 32'(a_prm), 32'(vecs[i].prm));
      chk($sformatf("v%0d valid", i), 32'(a_vld), 32'(vecs[i].vld));
    end

    // line now holds 10 (newest) .. 3 (oldest)
    for (int k = 0; k < 8; k++) chk($sformatf("fill tap%0d", k), 32'(a_taps[k*16 +: 16]),
                                    32'(10 - k));
    for (int s = 0; s < 8; s++) begin
      a_sel = 3'(s);
      #1;
      chk($sformatf("a tap_sel %0d", s), 32'(a_tout), 32'(10 - s));
    end

    // gapped strobes every 4th cycle
    gap_vals[0] = 16'd69;
    gap_vals[1] = 16'd88;
    gap_vals[2] = 16'd99;
    pulses   = 0;
    exp_tap0 = 16'd10;
    for (int c = 0; c < 12; c++) begin
      a_en  = (c % 4 == 0);
      a_din = a_en ? gap_vals[c / 4] : 16'hdead;
      if (a_en) exp_tap0 = a_din;
      tick();
      if (a_vld) pulses++;
      chk($sformatf("gap c%0d tap0", c), 32'(a_taps[15:0]), 32'(exp_tap0));
      chk($sformatf("gap c%0d valid", c), 32'(a_vld), 32'(c % 4 == 0));
    end
    a_en = 1'b0;
    chk("gap pulses", 32'(pulses), 32'd3);
    chk("gap data_out", 32'(a_dout), 32'd6);

    // clear beats a simultaneous strobe
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    for (int d = 1; d <= 8; d++) a_strobe(16'(d));
    chk("preclear primed", 32'(a_prm), 32'd1);
    a_clr = 1'b1;
    a_en  = 1'b1;
    a_din = 16'd123;
    tick();
    a_clr = 1'b0;
    a_en  = 1'b0;
    chk("clear taps", 32'(|a_taps), 32'd0);
    chk("clear fill", 32'(a_fill), 32'd0);
    chk("clear primed", 32'(a_prm), 32'd0);
    chk("clear valid", 32'(a_vld), 32'd0);
    a_strobe(16'd123);
    chk("refill tap0", 32'(a_taps[15:0]), 32'd123);
    chk("refill fill", 32'(a_fill), 32'd1);
    chk("refill primed", 32'(a_prm), 32'd0);
    chk("refill tap1", 32'(a_taps[31:16]), 32'd0);

    // depth 6 tap select, combinational
    b_en = 1'b1;
    for (int d = 1; d <= 6; d++) begin
      b_din = 16'(d * 10);
      tick();
    end
    b_en = 1'b0;
    chk("b primed", 32'(b_prm), 32'd1);
    chk("b fill", 32'(b_fill), 32'd6);
    b_sel = 3'd0; #1; chk("b sel0", 32'(b_tout), 32'd60);
    b_sel = 3'd5; #1; chk("b sel5", 32'(b_tout), 32'd10);
    b_sel = 3'd7; #1; chk("b sel7", 32'(b_tout), 32'd0);
    b_sel = 3'd6; #1; chk("b sel6", 32'(b_tout), 32'd0);
    b_sel = 3'd2; #1; chk("b sel2", 32'(b_tout), 32'd40);
    chk("b data_out", 32'(b_dout), 32'd10);

    // 24-bit extremes pass bit-exact through depth 3
    c_en  = 1'b1;
    c_din = 24'h800000; tick();
    c_din = 24'h7fffff; tick();
    c_din = 24'h000000; tick();
    chk("c dout 800000", 32'(c_dout), 32'h0080_0000);
    c_din = 24'h123456; tick();
    chk("c dout 7fffff", 32'(c_dout), 32'h007f_ffff);
    c_en = 1'b0;
    c_sel = 2'd3; #1; chk("c sel3", 32'(c_tout), 32'd0);
    c_sel = 2'd0; #1; chk("c sel0", 32'(c_tout), 32'h0012_3456);
    tick();
    chk("c hold", 32'(c_dout), 32'h007f_ffff);
    chk("c valid idle", 32'(c_vld), 32'd0);

    // mid-fill reset restarts counting
    c_rst = 1'b1;
    tick();
    c_rst = 1'b0;
    chk("c rst taps", 32'(|c_taps), 32'd0);
    chk("c rst fill", 32'(c_fill), 32'd0);
    c_en = 1'b1; c_din = 24'h000abc; tick(); c_en = 1'b0;
    chk("c refill fill", 32'(c_fill), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z_delay_line.md
# z_delay_line

Parametrised tapped delay line (z^-DEPTH) for the 8-band equalizer's FIR/IIR datapaths. Each sample strobe shifts a signed DATA_W-bit sample through DEPTH registers. The block exposes every tap to the MAC stage, provides a runtime-selectable single tap, and tracks when the line holds DEPTH valid samples. It replaces hand-chained unit-delay registers in the filter banks.

## Interface
- DATA_W, 16, sample width in bits (two's complement)
- DEPTH, 8, number of delay stages; legal range 1..64
- SEL_W, $clog2(DEPTH) (min 1), width of tap_sel
- clk  input  1  system clock; every register updates on the rising edge
- rst  input  1  reset; synchronous, active-high
- sample_en  input  1  one-cycle strobe at the audio sample rate; a shift happens only when this is high
- clear  input  1  synchronous flush of the line; lower priority than rst
- data_in  input  DATA_W  new sample, captured when sample_en=1
- tap_sel  input  SEL_W  index of the tap routed to tap_out
- taps  output  DATA_W*DEPTH  flat bus; bits [k*DATA_W +: DATA_W] = tap k (tap 0 = newest)
- tap_out  output  DATA_W  tap[tap_sel]
- data_out  output  DATA_W  tap[DEPTH-1], i.e. data_in delayed by DEPTH strobes
- out_valid  output  1  one-cycle pulse, the cycle after each accepted shift
- primed  output  1  high once DEPTH shifts have occurred since the last rst or clear
- fill_count  output  $clog2(DEPTH+1)  number of valid samples in the line, saturating at DEPTH

## Operation
- Priority per edge: rst > clear > sample_en > hold.
- rst=1: all taps, fill_count, primed and out_valid go to 0.
- clear=1 (rst=0): same effect as rst on taps, fill_count, primed and out_valid. sample_en in that cycle is ignored, so no sample is captured.
- sample_en=1 (rst=0, clear=0):
  - tap[0] <= data_in; tap[k] <= tap[k-1] for k=1..DEPTH-1.
  - fill_count <= min(fill_count+1, DEPTH).
  - out_valid <= 1.
- Otherwise: taps and fill_count hold; out_valid <= 0.
- primed is registered and set when the updated fill_count equals DEPTH. It stays high until rst or clear.
- No arithmetic on the data. Samples pass bit-exact, with no sign extension or truncation.
- tap_sel >= DEPTH (possible when DEPTH is not a power of 2): tap_out = 0.
- DEPTH=1: the block is a single enabled unit delay with valid tracking.
- Back-to-back sample_en on consecutive cycles is legal. Each strobe shifts once, and out_valid stays high for each following cycle.

## Timing
- Latency: a sample accepted on edge N appears on taps[0] after edge N. It reaches data_out after the (DEPTH-1)-th subsequent accepted strobe.
- out_valid and primed are registered and update on the same edge as the shift that causes them.
- tap_out is a combinational mux of registered taps. It responds to tap_sel in the same cycle; there is no pipeline register.
- rst or clear asserted mid-fill: the zero state is seen on the next edge, and refilling restarts from fill_count=0.
- All outputs are 0 from the first clk edge with rst=1.

## Structure
- Shared package/header eq_defs: default sample width EQ_SAMPLE_W=16 and the max-depth constant 64. The top level passes these to DATA_W and DEPTH.
- One sub-module, z_stage: a DATA_W register with sync rst, clear and enable. It is instantiated DEPTH times in a generate loop.
- fill_count, primed, out_valid logic and the tap_out mux live in z_delay_line itself.

## Test plan
- Reset: DEPTH=8, hold rst for 3 cycles with data_in=69 and sample_en=1 -> taps all 0, data_out=0, fill_count=0, primed=0, out_valid=0.
- Fill and delay: strobe 1,2,…,10 on consecutive cycles -> after the 8th strobe primed=1 and data_out=1; after the 10th, data_out=3, taps[0]=10, fill_count=8.
- Gapped strobes: apply sample_en every 4th cycle with values 69, 88, 99 -> taps change only on strobe edges; out_valid pulses exactly 3 times, one cycle each.
- Clear vs strobe: line holds 1..8, then assert clear and sample_en together with data_in=123 -> all taps 0, fill_count=0, primed=0; the next strobe with 123 gives taps[0]=123, fill_count=1.
- Tap select: DEPTH=6 holding 10..60 (newest 60) -> tap_sel=0 gives 60, tap_sel=5 gives 10, tap_sel=7 gives 0, all in the same cycle.
- Signed/width: DATA_W=24, strobe 0x800000 and 0x7FFFFF -> both values emerge bit-exact on data_out after DEPTH strobes.
